opendap_mem_ap_apb: RTL
=======================

# opendap_mem_ap_apb

MEM-AP sitting directly downstream of the SW-DP's AP interface: decodes AP register accesses (CSW, TAR, DRW, BD0–BD3, CFG, BASE, IDR) and converts DRW/BDn accesses into 32-bit APB3 master transfers. Provides the `ap_rdy`/`ap_err`/`ap_rdata` responses the DP expects, including abort handling and TAR auto-increment. One instance per APSEL value.

## Interface
- `APSEL`, 8'd0: AP number this instance answers to.
- `IDR`, 32'h0477_0002: value of the IDR register (0xFC).
- `BASE`, 32'h0000_0003: value of the BASE register (0xF8).
- `swclk` input 1: sole clock. All logic is clocked on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ap_sel` input 8: AP select, qualified by `ap_wen`/`ap_ren`.
- `ap_addr` input 6: word address {banksel, A[3:2]}, qualified by `ap_wen`/`ap_ren`.
- `ap_wdata` input 32: write data, valid from `ap_wen` until the cycle after `ap_rdy` rises.
- `ap_wen`, `ap_ren` input 1: single-cycle access strobes. They are never asserted together.
- `ap_abort` input 1: DAPABORT.
- `ap_rdata` output 32: read data.
- `ap_rdy` output 1: access complete or idle.
- `ap_err` output 1: access failed. Pulses only on the first `ap_rdy`-high cycle after a failed access.
- `paddr` output 32: APB address.
- `psel`, `penable`, `pwrite` output 1: APB controls.
- `pwdata` output 32: APB write data.
- `prdata` input 32: APB read data.
- `pready`, `pslverr` input 1: APB response.

## Operation
- **Selection.** An access is taken only when `ap_sel == APSEL`.
  - Non-selected accesses are ignored entirely: `ap_rdy` stays 1 and `ap_rdata` is unchanged.
  - Several instances' outputs are muxed outside this block.
- **CSW (0x00).**
  - [2:0] Size: RO, 3'b010.
  - [5:4] AddrInc: RW. Writing 2'b1x stores 2'b00.
  - [6] DeviceEn: RO, 1.
  - [7] TrInProg: RO, 1 while an APB transfer is active or draining.
  - [31]: RO, 1.
  - All other bits are RAZ/WI.
- **TAR (0x04).** RW [31:2]. Bits [1:0] are RAZ/WI.
- **DRW (0x0C).** APB transfer at `paddr = {TAR[31:2], 2'b00}`.
- **BDn (0x10–0x1C).** APB transfer at `paddr = {TAR[31:4], n[1:0], 2'b00}`. Never increments TAR.
- **Fixed registers.** CFG (0xF4) reads 0. BASE and IDR return their parameters.
- **Unmapped addresses.** Reads return 0, writes are ignored, and `ap_err` stays 0.
- **Auto-increment.** Applies after a DRW transfer that completes with `pslverr = 0` and AddrInc = 01.
  - TAR[9:2] increments by 1 and wraps within the 1 KiB page.
  - TAR[31:10] is unchanged.
- **APB errors.** `pslverr = 1` gives `ap_err = 1` on completion. TAR is not incremented. Read data is `prdata` as returned.
- **State machine.**
  - IDLE: `ap_rdy = 1`.
    - Register access goes to REG.
    - DRW/BDn access goes to SETUP.
  - REG: one cycle; performs the register write or latches read data into `ap_rdata`. Goes to IDLE.
  - SETUP: `psel = 1`, `penable = 0`. Goes to ACCESS.
  - ACCESS: `psel = 1`, `penable = 1`, held until `pready`.
    - On `pready`: latch `prdata` (reads), latch `pslverr`, go to IDLE.
- **Abort.**
  - When `ap_abort` is high in SETUP or ACCESS, `ap_rdy` = 1 on the next cycle with `ap_err = 0`. The state moves to DRAIN, or to IDLE if `pready` is 1 in that same cycle.
  - DRAIN: the APB transfer is kept legal (`psel`/`penable` stay high) until `pready`, and its result is discarded. TAR is not incremented.
  - A new selected access that arrives during DRAIN is captured. `ap_rdy` drops, and that access starts only after the drain finishes.
  - Abort in IDLE or REG has no effect.
- **APB output stability.** `paddr`, `pwrite` and `pwdata` are registered at SETUP entry and held stable through ACCESS/DRAIN.

## Timing
- **Reset values.**
  - `ap_rdy = 1`; `ap_err = 0`; `ap_rdata = 0`.
  - `psel = penable = pwrite = 0`; `paddr = pwdata = 0`.
  - CSW.AddrInc = 00; TAR = 0; state IDLE.
- **`ap_rdy` timing.**
  - `ap_rdy` drops the cycle after `ap_wen`/`ap_ren` (selected, not draining).
  - Register access: `ap_rdy` is low for exactly 1 cycle.
  - APB access with `pready` tied high: `ap_rdy` is low for 2 cycles. SETUP is cycle 1, ACCESS is cycle 2, and `ap_rdy` rises in cycle 3.
  - Each cycle of `pready = 0` adds one cycle.
- **Read data.** `ap_rdata` is valid from the `ap_rdy` rising cycle until the next selected `ap_wen`/`ap_ren`.
- **`ap_err`.** High for exactly one cycle, coincident with `ap_rdy` rising.
- **Reset mid-operation.** Reset during ACCESS drops `psel`/`penable` immediately (APB slaves share `rst`).

## Configuration
- `OPENDAP_MEM_AP_BD_EN` defined: BD0–BD3 are implemented as described above.
- `OPENDAP_MEM_AP_BD_EN` undefined:
  - 0x10–0x1C are unmapped (RAZ/WI, no APB transfer, 1-cycle REG response).
  - The BDn address mux is removed.

## Test plan
- **Reset and ID reads.** Reset, then read IDR → `ap_rdata = 32'h0477_0002`. Read CSW → 32'h8000_0042.
- **Auto-increment across the page boundary.** Write CSW = 32'h10, TAR = 32'h2000_03FC. Write DRW = 32'hCAFE_F00D with `pready` tied 1.
  - APB write at 0x2000_03FC.
  - TAR then reads 0x2000_0000.
  - `ap_rdy` is low for exactly 2 cycles.
- **Wait states and slave error.** Read DRW with `pready` low for 3 cycles and `pslverr = 1`.
  - `ap_rdy` is low for 5 cycles.
  - `ap_err` pulses once.
  - TAR is unchanged.
- **Abort during a stalled transfer.** Issue `ap_abort` while ACCESS is stalled.
  - `ap_rdy = 1` on the next cycle.
  - `psel` stays high until `pready`.
  - A following CSW read completes only after the drain.
- **Non-selected access.** Access with `ap_sel = APSEL+1` → no state change, `ap_rdy` stays 1, no APB activity.
- **Banked data (`OPENDAP_MEM_AP_BD_EN` defined).** With TAR = 0x100, read BD2 → APB read at 0x108, TAR unchanged. With the macro undefined → reads 0, no `psel`.

Source files
------------

// File: rtl/opendap_mem_ap_apb.sv
// opendap_mem_ap_apb
// MEM-AP behind the SW-DP AP interface. Decodes the AP register map
// (CSW, TAR, DRW, BD0-BD3, CFG, BASE, IDR) and turns DRW/BDn accesses into
// 32-bit APB3 master transfers, with abort/drain handling and TAR auto-increment.
// Build option: define OPENDAP_MEM_AP_BD_EN to implement BD0-BD3; otherwise
// 0x10-0x1C behave as unmapped registers.
module opendap_mem_ap_apb #(
    parameter logic [7:0]  APSEL = 8'd0,
    parameter logic [31:0] IDR   = 32'h0477_0002,
    parameter logic [31:0] BASE  = 32'h0000_0003
) (
    input  logic        swclk,
    input  logic        rst,
    input  logic [7:0]  ap_sel,
    input  logic [5:0]  ap_addr,
    input  logic [31:0] ap_wdata,
    input  logic        ap_wen,
    input  logic        ap_ren,
    input  logic        ap_abort,
    output logic [31:0] ap_rdata,
    output logic        ap_rdy,
    output logic        ap_err,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    localparam logic [5:0] A_CSW  = 6'h00;
    localparam logic [5:0] A_TAR  = 6'h01;
    localparam logic [5:0] A_DRW  = 6'h03;
    localparam logic [5:0] A_CFG  = 6'h3D;
    localparam logic [5:0] A_BASE = 6'h3E;
    localparam logic [5:0] A_IDR  = 6'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REG,
        S_SETUP,
        S_ACCESS,
        S_DRAIN
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // TAR[31:2]; bits [1:0] are not stored
    logic [29:0] tar_q;
    logic [1:0]  addr_inc_q;

    // Current (or pending) access captured when it is accepted
    logic [5:0]  acc_addr;
    logic        acc_write;
    logic [31:0] acc_wdata;
    logic        pend_vld;

    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic        pwrite_q;

    logic        acc_req;
    logic        take;
    logic        disp;
    logic        trinprog;
    logic        xfer_done;
    logic        tar_inc;
    logic [5:0]  d_addr;
    logic        d_write;
    logic [31:0] d_wdata;
    logic        d_is_apb;
    logic [31:0] d_paddr;
    logic [31:0] csw_val;
    logic [31:0] reg_rdata;

    assign acc_req = (ap_sel == APSEL) && (ap_wen || ap_ren);
    // New accesses are accepted while idle, or once (and only once) while draining
    assign take    = acc_req && ((state == S_IDLE) || ((state == S_DRAIN) && !pend_vld));
    // An access starts immediately from IDLE, or as soon as the drain completes
    assign disp    = ((state == S_IDLE) && acc_req) ||
                     ((state == S_DRAIN) && pready && (pend_vld || acc_req));

    // A non-aborted transfer completing this cycle
    assign xfer_done = (state == S_ACCESS) && pready && !ap_abort;
    assign tar_inc   = xfer_done && !pslverr && (acc_addr == A_DRW) && (addr_inc_q == 2'b01);

    // Dispatch source: a held pending access takes priority over the live inputs
    always_comb begin
        if (pend_vld) begin
            d_addr  = acc_addr;
            d_write = acc_write;
            d_wdata = acc_wdata;
        end else begin
            d_addr  = ap_addr;
            d_write = ap_wen;
            d_wdata = ap_wdata;
        end
    end

`ifdef OPENDAP_MEM_AP_BD_EN
    logic d_is_bd;
    assign d_is_bd  = (d_addr[5:2] == 4'b0001);
    assign d_is_apb = (d_addr == A_DRW) || d_is_bd;
    assign d_paddr  = d_is_bd ? {tar_q[29:2], d_addr[1:0], 2'b00} : {tar_q, 2'b00};
`else
    assign d_is_apb = (d_addr == A_DRW);
    assign d_paddr  = {tar_q, 2'b00};
`endif

    assign csw_val = {1'b1, 23'd0, trinprog, 1'b1, addr_inc_q, 1'b0, 3'b010};

    // Register read mux for the REG state
    always_comb begin
        case (acc_addr)
            A_CSW:   reg_rdata = csw_val;
            A_TAR:   reg_rdata = {tar_q, 2'b00};
            A_CFG:   reg_rdata = 32'd0;
            A_BASE:  reg_rdata = BASE;
            A_IDR:   reg_rdata = IDR;
            default: reg_rdata = 32'd0;
        endcase
    end

    // FSM state register
    always_ff @(posedge swclk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (disp) begin
                    state_nxt = d_is_apb ? S_SETUP : S_REG;
                end
            end
            S_REG: begin
                state_nxt = S_IDLE;
            end
            S_SETUP: begin
                state_nxt = ap_abort ? S_DRAIN : S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    state_nxt = S_IDLE;
                end else if (ap_abort) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pready) begin
                    if (disp) begin
                        state_nxt = d_is_apb ? S_SETUP : S_REG;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from state
    always_comb begin
        psel     = (state == S_SETUP) || (state == S_ACCESS) || (state == S_DRAIN);
        penable  = (state == S_ACCESS) || (state == S_DRAIN);
        trinprog = psel;
        ap_rdy   = (state == S_IDLE) || ((state == S_DRAIN) && !pend_vld);
    end

    // Access capture, register file, APB request registers and responses
    always_ff @(posedge swclk) begin
        if (rst) begin
            pend_vld   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            tar_q      <= 30'd0;
            addr_inc_q <= 2'b00;
            paddr_q    <= 32'd0;
            pwdata_q   <= 32'd0;
            pwrite_q   <= 1'b0;
        end else begin
            err_q <= xfer_done && pslverr;

            if (take) begin
                acc_addr  <= ap_addr;
                acc_write <= ap_wen;
                acc_wdata <= ap_wdata;
            end

            if (state == S_DRAIN) begin
                if (pready) begin
                    pend_vld <= 1'b0;
                end else if (take) begin
                    pend_vld <= 1'b1;
                end
            end

            if (disp && d_is_apb) begin
                paddr_q  <= d_paddr;
                pwrite_q <= d_write;
                pwdata_q <= d_wdata;
            end

            if (state == S_REG) begin
                if (acc_write) begin
                    if (acc_addr == A_CSW) begin
                        addr_inc_q <= acc_wdata[5] ? 2'b00 : acc_wdata[5:4];
                    end else if (acc_addr == A_TAR) begin
                        tar_q <= acc_wdata[31:2];
                    end
                end else begin
                    rdata_q <= reg_rdata;
                end
            end

            if (xfer_done && !pwrite_q) begin
                rdata_q <= prdata;
            end

            // Increment wraps inside the 1 KiB page: only TAR[9:2] moves
            if (tar_inc) begin
                tar_q[7:0] <= tar_q[7:0] + 8'd1;
            end
        end
    end

    assign ap_rdata = rdata_q;
    assign ap_err   = err_q;
    assign paddr    = paddr_q;
    assign pwrite   = pwrite_q;
    assign pwdata   = pwdata_q;

endmodule
